// File: rtl/wasca_hex_dimmer.sv
// wasca_hex_dimmer: brightness/blink stage between a 7-bit hex-digit PIO and
// the board's active-low 7-segment pins, configured via a small Avalon-MM slave.
// Register map: 0 CTRL {blink_en, enable}, 1 BRIGHT level[3:0],
//               2 BLINK half[7:0], 3 STATUS {pwm_cnt[7:4], blink_phase[0]} (RO).
// Build option: define WASCA_HEX_DIMMER_GAMMA_EN to map the brightness level
// through a perceptual table instead of using it directly as the PWM threshold.
module wasca_hex_dimmer #(
   parameter int unsigned PRESCALE_DIV = 3125
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [6:0]  seg_in,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic [6:0]  seg_out_n
);

   localparam int unsigned SEG_W   = 7;
   localparam int unsigned PRE_W   = 16;
   localparam int unsigned PWM_W   = 4;
   localparam int unsigned HALF_W  = 8;
   localparam int unsigned BLINK_W = 12;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_BRIGHT = 2'd1;
   localparam logic [1:0] ADDR_BLINK  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   logic               ctrl_enable;
   logic               ctrl_blink_en;
   logic [PWM_W-1:0]   bright_level;
   logic [HALF_W-1:0]  blink_half;

   logic [PRE_W-1:0]   pre_cnt;
   logic [PWM_W-1:0]   pwm_cnt;
   logic [SEG_W-1:0]   seg_shadow;
   logic [PWM_W-1:0]   bright_shadow;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase;

   logic               wr_c;
   logic               tick_c;
   logic               boundary_c;
   logic [PWM_W-1:0]   thr_c;
   logic               pwm_on_c;
   logic               on_c;
   logic [BLINK_W-1:0] blink_last_c;
   logic               unused_wdata_c;

   assign wr_c           = chipselect & ~write_n;
   assign tick_c         = (pre_cnt == PRE_LAST);
   assign boundary_c     = tick_c & (pwm_cnt == PWM_W'(15));
   assign blink_last_c   = {blink_half, 4'hF};
   assign unused_wdata_c = ^writedata[31:8];

   // Configuration registers; STATUS is read-only so writes to it fall through
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_enable   <= 1'b1;
         ctrl_blink_en <= 1'b0;
         bright_level  <= PWM_W'(15);
         blink_half    <= HALF_W'(8'h1F);
      end else if (wr_c) begin
         case (address)
            ADDR_CTRL: begin
               ctrl_enable   <= writedata[0];
               ctrl_blink_en <= writedata[1];
            end
            ADDR_BRIGHT: bright_level <= writedata[PWM_W-1:0];
            ADDR_BLINK:  blink_half   <= writedata[HALF_W-1:0];
            default: ;
         endcase
      end
   end

   // Prescaler: one PWM tick every PRESCALE_DIV clocks
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pre_cnt <= '0;
      end else if (tick_c) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   // PWM phase counter, wraps naturally 15 -> 0
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pwm_cnt <= '0;
      end else if (tick_c) begin
         pwm_cnt <= pwm_cnt + PWM_W'(1);
      end
   end

   // Shadows only change at the period boundary so a PWM period is never torn
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg_shadow    <= '0;
         bright_shadow <= PWM_W'(15);
      end else if (boundary_c) begin
         seg_shadow    <= seg_in;
         bright_shadow <= bright_level;
      end
   end

   // Level to duty threshold
`ifdef WASCA_HEX_DIMMER_GAMMA_EN
   always_comb begin
      thr_c = PWM_W'(15);
      case (bright_shadow)
         4'd0:    thr_c = 4'd0;
         4'd1:    thr_c = 4'd0;
         4'd2:    thr_c = 4'd0;
         4'd3:    thr_c = 4'd1;
         4'd4:    thr_c = 4'd1;
         4'd5:    thr_c = 4'd2;
         4'd6:    thr_c = 4'd2;
         4'd7:    thr_c = 4'd3;
         4'd8:    thr_c = 4'd4;
         4'd9:    thr_c = 4'd5;
         4'd10:   thr_c = 4'd6;
         4'd11:   thr_c = 4'd7;
         4'd12:   thr_c = 4'd9;
         4'd13:   thr_c = 4'd10;
         4'd14:   thr_c = 4'd12;
         default: thr_c = 4'd15;
      endcase
   end
`else
   assign thr_c = bright_shadow;
`endif

   assign pwm_on_c = (pwm_cnt <= thr_c);
   assign on_c     = ctrl_enable & pwm_on_c & blink_phase;

   // Blink timer counts PWM periods; a BLINK write restarts it in the lit phase
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (!ctrl_blink_en) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (wr_c && (address == ADDR_BLINK)) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b1;
      end else if (boundary_c) begin
         if (blink_cnt == blink_last_c) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
         end
      end
   end

   // Registered active-low pin drive
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg_out_n <= 7'h7F;
      end else begin
         seg_out_n <= ~(seg_shadow & {SEG_W{on_c}});
      end
   end

   // Zero-wait-state read mux
   always_comb begin
      readdata = '0;
      case (address)
         ADDR_CTRL:   readdata[1:0] = {ctrl_blink_en, ctrl_enable};
         ADDR_BRIGHT: readdata[PWM_W-1:0] = bright_level;
         ADDR_BLINK:  readdata[HALF_W-1:0] = blink_half;
         ADDR_STATUS: begin
            readdata[7:4] = pwm_cnt;
            readdata[0]   = blink_phase;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wasca_hex_dimmer.sv
// Bench for wasca_hex_dimmer with PRESCALE_DIV = 2 (32-clk PWM period).
// Honours WASCA_HEX_DIMMER_GAMMA_EN when the same define is given.
module tb_wasca_hex_dimmer;

   localparam int unsigned PDIV = 2;

   logic        clk;
   logic        reset_n;
   logic [6:0]  seg_in;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [6:0]  seg_out_n;

   int checks = 0;
   int errors = 0;

   wasca_hex_dimmer #(.PRESCALE_DIV(PDIV)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .seg_in     (seg_in),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .seg_out_n  (seg_out_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int thr_of(input int lvl);
      int g [16];
      g = '{0, 0, 0, 1, 1, 2, 2, 3, 4, 5, 6, 7, 9, 10, 12, 15};
`ifdef WASCA_HEX_DIMMER_GAMMA_EN
      return g[lvl];
`else
      return (g[0] * 0) + lvl;
`endif
   endfunction

   // Reference model: position in the 32-clk period is a plain cycle count
   int         m_cyc;
   bit         m_en, m_ben, m_phase;
   int         m_bright, m_half, m_bright_sh, m_bcnt;
   logic [6:0] m_seg_sh;
   logic [6:0] m_e;
   bit         m_on, m_wr, m_bnd;
   logic [6:0] exp_q [$];
   logic [6:0] sb_exp;

   always @(posedge clk) begin
      if (!reset_n) begin
         m_cyc = 0; m_en = 1; m_ben = 0; m_phase = 1;
         m_bright = 15; m_half = 31; m_bright_sh = 15; m_bcnt = 0;
         m_seg_sh = 7'h00;
         m_e = 7'h7F;
      end else begin
         m_on  = m_en && ((m_cyc / 2) <= thr_of(m_bright_sh)) && m_phase;
         m_e   = m_on ? ~m_seg_sh : 7'h7F;
         m_wr  = chipselect && !write_n;
         m_bnd = (m_cyc == 31);
         if (!m_ben) begin
            m_bcnt = 0; m_phase = 1;
         end else if (m_wr && address == 2'd2) begin
            m_bcnt = 0; m_phase = 1;
         end else if (m_bnd) begin
            if (m_bcnt == m_half * 16 + 15) begin
               m_bcnt = 0; m_phase = !m_phase;
            end else begin
               m_bcnt++;
            end
         end
         if (m_bnd) begin
            m_seg_sh = seg_in; m_bright_sh = m_bright;
         end
         if (m_wr) begin
            case (address)
               2'd0: begin m_en = writedata[0]; m_ben = writedata[1]; end
               2'd1: m_bright = int'(writedata[3:0]);
               2'd2: m_half = int'(writedata[7:0]);
               default: ;
            endcase
         end
         m_cyc = (m_cyc + 1) % 32;
      end
      exp_q.push_back(m_e);
   end

   function automatic logic [31:0] status_exp();
      return {24'd0, 4'(m_cyc / 2), 3'd0, m_phase};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   // Drive a write in the current cycle, release at the next negedge
   task automatic wr_now(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      wr_now(a, d);
   endtask

   task automatic rd_chk(input logic [1:0] a, input logic [31:0] req, input string name);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      #1;
      chk(name, readdata, req);
      chipselect = 1'b0;
   endtask

   task automatic wait_mcyc(input int v);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (m_cyc != v && n < 100);
      if (m_cyc != v) begin
         checks++; errors++;
         $display("FAIL wait_mcyc timeout actual=%0d required=%0d", m_cyc, v);
      end
   endtask

   task automatic measure(input int n, output int low0, output int low1, output int bad_rest);
      low0 = 0; low1 = 0; bad_rest = 0;
      repeat (n) begin
         @(negedge clk);
         if (!seg_out_n[0]) low0++;
         if (!seg_out_n[1]) low1++;
         if (seg_out_n[6:2] != 5'h1F) bad_rest++;
      end
   endtask

   // Poll STATUS[0] each cycle until it equals target; n counts polled cycles
   task automatic poll_phase(input bit target, input int budget, output int n, output int blank);
      n = 0; blank = 0;
      address = 2'd3; chipselect = 1'b1; write_n = 1'b1;
      do begin
         @(negedge clk);
         #1;
         n++;
         if (seg_out_n == 7'h7F) blank++;
      end while (readdata[0] !== target && n < budget);
      if (readdata[0] !== target) begin
         checks++; errors++;
         $display("FAIL poll_phase timeout actual=%0b required=%0b", readdata[0], target);
      end
   endtask

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] req;
   } reg_vec_t;

   reg_vec_t vecs [6];

   initial begin
      #1000000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int l0, l1, lr, n, blank, bad;

      vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0003};
      vecs[1] = '{2'd1, 32'h0000_ABCD, 32'h0000_000D};
      vecs[2] = '{2'd2, 32'h0001_2345, 32'h0000_0045};
      vecs[3] = '{2'd0, 32'h0000_0001, 32'h0000_0001};
      vecs[4] = '{2'd1, 32'h0000_000F, 32'h0000_000F};
      vecs[5] = '{2'd2, 32'h0000_001F, 32'h0000_001F};

      reset_n = 1'b0; seg_in = 7'h3F; address = 2'd0;
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;

      // Scoreboard: one expected pin value per clock, compared half a cycle later
      fork
         forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
               sb_exp = exp_q.pop_front();
               chk("scoreboard_seg_out_n", 32'(seg_out_n), 32'(sb_exp));
            end
         end
      join_none

      // Reset values
      repeat (3) @(negedge clk);
      chk("reset_seg_out_n", 32'(seg_out_n), 32'h7F);
      rd_chk(2'd0, 32'h1, "reset_ctrl");
      rd_chk(2'd1, 32'hF, "reset_bright");
      rd_chk(2'd2, 32'h1F, "reset_blink");
      rd_chk(2'd3, 32'h1, "reset_status");
      reset_n = 1'b1;

      // Full-brightness pattern settles after the first boundary
      repeat (40) @(negedge clk);
      bad = 0;
      repeat (64) begin
         @(negedge clk);
         if (seg_out_n != 7'h40) bad++;
      end
      chk("reset_const_40_bad_cycles", bad, 0);
      rd_chk(2'd1, 32'hF, "post_reset_bright");
      rd_chk(2'd2, 32'h1F, "post_reset_blink");

      // Register write/readback table
      for (int i = 0; i < 6; i++) begin
         bus_write(vecs[i].addr, vecs[i].wdata);
         rd_chk(vecs[i].addr, vecs[i].req, $sformatf("reg_vec%0d", i));
      end
      bus_write(2'd3, 32'hFFFF_FFFF);
      rd_chk(2'd3, status_exp(), "status_write_ignored");

      // Brightness 3 on segment 0
      bus_write(2'd1, 32'd3);
      seg_in = 7'h01;
      wait_mcyc(1);
      wait_mcyc(1);
      measure(32, l0, l1, lr);
      chk("bright3_low_cycles", l0, 2 * (thr_of(3) + 1));
      chk("bright3_bit1_low", l1, 0);
      chk("bright3_rest_low", lr, 0);

      // BRIGHT write in the boundary cycle, seg_in changed right after it
      wait_mcyc(31);
      wr_now(2'd1, 32'd15);
      seg_in = 7'h02;
      measure(32, l0, l1, lr);
      chk("glitch_old_bit0_low", l0, 2 * (thr_of(3) + 1));
      chk("glitch_old_bit1_low", l1, 0);
      measure(32, l0, l1, lr);
      chk("glitch_new_bit0_low", l0, 0);
      chk("glitch_new_bit1_low", l1, 2 * (thr_of(15) + 1));
      chk("glitch_new_rest_low", lr, 0);

      // Enable off mid-period, then back on
      wait_mcyc(10);
      wr_now(2'd0, 32'd0);
      chk("en_off_plus1", 32'(seg_out_n), 32'h7D);
      @(negedge clk);
      chk("en_off_plus2", 32'(seg_out_n), 32'h7F);
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (seg_out_n != 7'h7F) bad++;
      end
      chk("en_off_hold_bad", bad, 0);
      wait_mcyc(20);
      wr_now(2'd0, 32'd1);
      chk("en_on_plus1", 32'(seg_out_n), 32'h7F);
      @(negedge clk);
      chk("en_on_plus2", 32'(seg_out_n), 32'h7D);

      // Blink with half = 0: 16 periods lit, 16 blank
      bus_write(2'd2, 32'd0);
      bus_write(2'd0, 32'd3);
      poll_phase(1'b0, 1200, n, blank);
      chk("blink_first_lit_blank", blank, 0);
      rd_chk(2'd3, status_exp(), "blink_status_model");
      poll_phase(1'b1, 1200, n, blank);
      chk("blink_blank_len", n, 512);
      chk("blink_blank_seg_off", blank, 512);
      poll_phase(1'b0, 1200, n, blank);
      chk("blink_lit_len", n, 512);
      chk("blink_lit_seg_on", blank, 0);

      // BLINK rewrite mid-blank relights immediately
      repeat (100) @(negedge clk);
      wr_now(2'd2, 32'd0);
      chk("rewrite_still_blank", 32'(seg_out_n), 32'h7F);
      address = 2'd3;
      #1;
      chk("rewrite_phase", 32'(readdata[0]), 32'h1);
      @(negedge clk);
      chk("rewrite_relit", 32'(seg_out_n), 32'h7D);

      // One-clock reset while blanked
      poll_phase(1'b0, 1200, n, blank);
      reset_n = 1'b0;
      @(negedge clk);
      chk("midrst_seg_off", 32'(seg_out_n), 32'h7F);
      reset_n = 1'b1;
      rd_chk(2'd3, 32'h01, "midrst_status");
      rd_chk(2'd0, 32'h1, "midrst_ctrl");
      rd_chk(2'd1, 32'hF, "midrst_bright");
      rd_chk(2'd2, 32'h1F, "midrst_blink");
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
